pe_mac_lanes: RTL and testbench

PE_MAC_LANES -- requirements
Module: pe_mac_lanes

---
 rtl/pe_pkg.sv | 17 +
 rtl/pe_lane_sum.sv | 32 +++
 rtl/pe_mac_lanes.sv | 240 ++++++++++++++++++++++++
 tb/tb_pe_mac_lanes.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the pe_mac_lanes processing element:
// the sequence-tracking FSM encoding and the accumulator width floor.
package pe_pkg;

   // Sequence tracking: IDLE waits for a first beat, ACCUM is inside a sequence.
   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ACCUM = 1'b1
   } pe_state_e;

   // Smallest accumulator that holds one beat's full sum of LANES products.
   function automatic int unsigned acc_width_min(input int unsigned width,
                                                 input int unsigned lanes);
      return 2 * width + $clog2(lanes);
   endfunction

endpackage

// File: rtl/pe_lane_sum.sv
// Combinational adder tree: LANES full-width products, each extended to
// ACC_WIDTH (sign- or zero-extended per SIGNED), summed modulo 2^ACC_WIDTH.
// Ports:
//   prod  - LANES packed products of 2*WIDTH bits, lane 0 at LSBs
//   sum_c - ACC_WIDTH sum of all lanes (combinational)
module pe_lane_sum
   import pe_pkg::*;
#(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned LANES     = 4,
   parameter int unsigned ACC_WIDTH = 40,
   parameter bit          SIGNED    = 1'b1
) (
   input  logic [LANES*2*WIDTH-1:0] prod,
   output logic [ACC_WIDTH-1:0]     sum_c
);

   localparam int unsigned PW = 2 * WIDTH;

   // Extend each lane to the accumulator width and add.
   always_comb begin
      sum_c = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         if (SIGNED) begin
            sum_c = sum_c + ACC_WIDTH'($signed(prod[i*PW +: PW]));
         end else begin
            sum_c = sum_c + ACC_WIDTH'(prod[i*PW +: PW]);
         end
      end
   end

endmodule

// File: rtl/pe_mac_lanes.sv
// Systolic multi-lane MAC processing element.
// Operands flow west->east (a) and north->south (b) with one cycle of
// forwarding; accepted beats are multiplied per lane (stage 1), summed into
// an accumulator (stage 2), and a completed sequence result is buffered and
// merged into the drain chain ahead of upstream drain data.
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   in_valid/in_ready           - operand beat handshake
//   in_first/in_last            - sequence delimiters
//   in_a/in_b                   - LANES operands each, lane 0 at LSBs
//   out_valid/out_a/out_b/
//   out_first/out_last          - registered copy of the accepted beat
//   drain_in_valid/ready/data   - upstream result chain input
//   drain_out_valid/data,
//   drain_ready                 - result chain output
//   acc_ovf                     - sticky overflow of current/last sequence
//   protocol_err                - sticky framing error
module pe_mac_lanes
   import pe_pkg::*;
#(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned LANES     = 4,
   parameter int unsigned ACC_WIDTH = 40,
   parameter bit          SIGNED    = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_first,
   input  logic                   in_last,
   input  logic [LANES*WIDTH-1:0] in_a,
   input  logic [LANES*WIDTH-1:0] in_b,
   output logic                   out_valid,
   output logic [LANES*WIDTH-1:0] out_a,
   output logic [LANES*WIDTH-1:0] out_b,
   output logic                   out_first,
   output logic                   out_last,
   input  logic                   drain_in_valid,
   output logic                   drain_in_ready,
   input  logic [ACC_WIDTH-1:0]   drain_in_data,
   output logic                   drain_out_valid,
   input  logic                   drain_ready,
   output logic [ACC_WIDTH-1:0]   drain_out_data,
   output logic                   acc_ovf,
   output logic                   protocol_err
);

   localparam int unsigned DW      = LANES * WIDTH;
   localparam int unsigned PW      = 2 * WIDTH;
   localparam int unsigned ACC_MIN = acc_width_min(WIDTH, LANES);

   if (ACC_WIDTH < ACC_MIN) begin : g_acc_width_check
      $error("pe_mac_lanes: ACC_WIDTH below 2*WIDTH+clog2(LANES)");
   end

   pe_state_e               state_q, state_d;
   logic                    out_valid_q, out_valid_d;
   logic [DW-1:0]           out_a_q, out_a_d, out_b_q, out_b_d;
   logic                    out_first_q, out_first_d, out_last_q, out_last_d;
   logic                    s1_valid_q, s1_valid_d;
   logic                    s1_first_q, s1_first_d, s1_last_q, s1_last_d;
   logic [LANES*PW-1:0]     s1_prod_q, s1_prod_d;
   logic [ACC_WIDTH-1:0]    acc_q, acc_d;
   logic                    acc_ovf_q, acc_ovf_d;
   logic [ACC_WIDTH-1:0]    res_buf_q, res_buf_d;
   logic                    res_valid_q, res_valid_d;
   logic                    dout_valid_q, dout_valid_d;
   logic [ACC_WIDTH-1:0]    dout_data_q, dout_data_d;
   logic                    prot_err_q, prot_err_d;

   logic                    beat_c, acc_beat_c, err_c;
   logic [LANES*PW-1:0]     prod_c;
   logic [ACC_WIDTH-1:0]    sum_c, base_c, add_c;
   logic                    carry_c, ovf_now_c;
   logic                    res_load_c, res_xfer_c, din_take_c;

   // Operand extension to product width so a plain multiply yields the full product.
   function automatic logic [PW-1:0] ext_op(input logic [WIDTH-1:0] x);
      return SIGNED ? {{WIDTH{x[WIDTH-1]}}, x} : {{WIDTH{1'b0}}, x};
   endfunction

   // Stall while a result is on its way to, or sitting in, the result buffer.
   assign in_ready       = !res_valid_q && !(s1_valid_q && s1_last_q);
   assign beat_c         = in_valid && in_ready;
   assign drain_in_ready = (!dout_valid_q || drain_ready) && !res_valid_q;

   // Per-lane products of the incoming beat.
   always_comb begin
      prod_c = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         prod_c[i*PW +: PW] = ext_op(in_a[i*WIDTH +: WIDTH]) * ext_op(in_b[i*WIDTH +: WIDTH]);
      end
   end

   pe_lane_sum #(
      .WIDTH     (WIDTH),
      .LANES     (LANES),
      .ACC_WIDTH (ACC_WIDTH),
      .SIGNED    (SIGNED)
   ) u_lane_sum (
      .prod  (s1_prod_q),
      .sum_c (sum_c)
   );

   // Sequence FSM: decides whether an accepted beat accumulates and flags framing errors.
   always_comb begin
      state_d    = state_q;
      acc_beat_c = 1'b0;
      err_c      = 1'b0;
      if (beat_c) begin
         unique case (state_q)
            ST_IDLE: begin
               if (in_first) begin
                  acc_beat_c = 1'b1;
                  state_d    = in_last ? ST_IDLE : ST_ACCUM;
               end else begin
                  err_c = 1'b1;
               end
            end
            ST_ACCUM: begin
               acc_beat_c = 1'b1;
               err_c      = in_first;
               state_d    = in_last ? ST_IDLE : ST_ACCUM;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Forwarding, stage 1, stage 2, result buffer and drain merge.
   always_comb begin
      out_valid_d = beat_c;
      out_a_d     = out_a_q;
      out_b_d     = out_b_q;
      out_first_d = out_first_q;
      out_last_d  = out_last_q;
      if (beat_c) begin
         out_a_d     = in_a;
         out_b_d     = in_b;
         out_first_d = in_first;
         out_last_d  = in_last;
      end

      s1_valid_d = acc_beat_c;
      s1_first_d = s1_first_q;
      s1_last_d  = s1_last_q;
      s1_prod_d  = s1_prod_q;
      if (acc_beat_c) begin
         s1_first_d = in_first;
         s1_last_d  = in_last;
         s1_prod_d  = prod_c;
      end

      // A first beat restarts from zero, discarding any partial sum.
      base_c             = s1_first_q ? '0 : acc_q;
      {carry_c, add_c}   = {1'b0, base_c} + {1'b0, sum_c};
      ovf_now_c          = SIGNED ? ((base_c[ACC_WIDTH-1] == sum_c[ACC_WIDTH-1]) &&
                                     (add_c[ACC_WIDTH-1] != base_c[ACC_WIDTH-1]))
                                  : carry_c;
      acc_d     = acc_q;
      acc_ovf_d = acc_ovf_q;
      if (s1_valid_q) begin
         acc_d     = add_c;
         acc_ovf_d = s1_first_q ? ovf_now_c : (acc_ovf_q || ovf_now_c);
      end

      res_load_c  = s1_valid_q && s1_last_q;
      res_xfer_c  = res_valid_q && (!dout_valid_q || drain_ready);
      din_take_c  = drain_in_valid && drain_in_ready;
      res_buf_d   = res_load_c ? add_c : res_buf_q;
      res_valid_d = res_load_c ? 1'b1 : (res_xfer_c ? 1'b0 : res_valid_q);

      // Local result wins over upstream data; drain_in_ready already excludes the clash.
      dout_valid_d = dout_valid_q;
      dout_data_d  = dout_data_q;
      if (res_xfer_c) begin
         dout_valid_d = 1'b1;
         dout_data_d  = res_buf_q;
      end else if (din_take_c) begin
         dout_valid_d = 1'b1;
         dout_data_d  = drain_in_data;
      end else if (drain_ready) begin
         dout_valid_d = 1'b0;
      end

      prot_err_d = prot_err_q || err_c;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         out_valid_q  <= 1'b0;
         out_a_q      <= '0;
         out_b_q      <= '0;
         out_first_q  <= 1'b0;
         out_last_q   <= 1'b0;
         s1_valid_q   <= 1'b0;
         s1_first_q   <= 1'b0;
         s1_last_q    <= 1'b0;
         s1_prod_q    <= '0;
         acc_q        <= '0;
         acc_ovf_q    <= 1'b0;
         res_buf_q    <= '0;
         res_valid_q  <= 1'b0;
         dout_valid_q <= 1'b0;
         dout_data_q  <= '0;
         prot_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         out_valid_q  <= out_valid_d;
         out_a_q      <= out_a_d;
         out_b_q      <= out_b_d;
         out_first_q  <= out_first_d;
         out_last_q   <= out_last_d;
         s1_valid_q   <= s1_valid_d;
         s1_first_q   <= s1_first_d;
         s1_last_q    <= s1_last_d;
         s1_prod_q    <= s1_prod_d;
         acc_q        <= acc_d;
         acc_ovf_q    <= acc_ovf_d;
         res_buf_q    <= res_buf_d;
         res_valid_q  <= res_valid_d;
         dout_valid_q <= dout_valid_d;
         dout_data_q  <= dout_data_d;
         prot_err_q   <= prot_err_d;
      end
   end

   assign out_valid       = out_valid_q;
   assign out_a           = out_a_q;
   assign out_b           = out_b_q;
   assign out_first       = out_first_q;
   assign out_last        = out_last_q;
   assign drain_out_valid = dout_valid_q;
   assign drain_out_data  = dout_data_q;
   assign acc_ovf         = acc_ovf_q;
   assign protocol_err    = prot_err_q;

endmodule

// File: tb/tb_pe_mac_lanes.sv
// Self-checking bench for pe_mac_lanes (LANES=4, WIDTH=16, ACC_WIDTH=40, signed).
module tb_pe_mac_lanes;

   localparam int unsigned W  = 16;
   localparam int unsigned L  = 4;
   localparam int unsigned AW = 40;
   localparam int unsigned DW = L * W;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid, in_ready, in_first, in_last;
   logic [DW-1:0] in_a, in_b;
   logic          out_valid, out_first, out_last;
   logic [DW-1:0] out_a, out_b;
   logic          drain_in_valid, drain_in_ready;
   logic [AW-1:0] drain_in_data;
   logic          drain_out_valid, drain_ready;
   logic [AW-1:0] drain_out_data;
   logic          acc_ovf, protocol_err;

   int n_tests = 0;
   int n_fail  = 0;

   logic [DW-1:0] seq_a [200];
   logic [DW-1:0] seq_b [200];
   bit            seq_f [200];

   always #5 clk = ~clk;

   pe_mac_lanes #(.WIDTH(W), .LANES(L), .ACC_WIDTH(AW), .SIGNED(1'b1)) dut (
      .clk             (clk),
      .reset           (reset),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_first        (in_first),
      .in_last         (in_last),
      .in_a            (in_a),
      .in_b            (in_b),
      .out_valid       (out_valid),
      .out_a           (out_a),
      .out_b           (out_b),
      .out_first       (out_first),
      .out_last        (out_last),
      .drain_in_valid  (drain_in_valid),
      .drain_in_ready  (drain_in_ready),
      .drain_in_data   (drain_in_data),
      .drain_out_valid (drain_out_valid),
      .drain_ready     (drain_ready),
      .drain_out_data  (drain_out_data),
      .acc_ovf         (acc_ovf),
      .protocol_err    (protocol_err)
   );

   function automatic logic [DW-1:0] pack4(input int x0, input int x1, input int x2, input int x3);
      return {16'(x3), 16'(x2), 16'(x1), 16'(x0)};
   endfunction

   // Reference: exact integer dot products, per-sequence restart on first,
   // signed 40-bit range check after each beat with wrap on overflow.
   function automatic void model_seq(input int n, output logic [AW-1:0] res, output bit ovf);
      longint acc = 0;
      longint lim = longint'(1) << 39;
      longint s;
      ovf = 1'b0;
      for (int k = 0; k < n; k++) begin
         if (seq_f[k]) begin
            acc = 0;
            ovf = 1'b0;
         end
         s = 0;
         for (int l = 0; l < 4; l++) begin
            s += longint'($signed(seq_a[k][l*16 +: 16])) * longint'($signed(seq_b[k][l*16 +: 16]));
         end
         acc += s;
         if (acc >= lim || acc < -lim) begin
            ovf = 1'b1;
            acc = longint'($signed(acc[39:0]));
         end
      end
      res = acc[39:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_beat(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit f, input bit l);
      int waited = 0;
      while (!in_ready && waited < 50) begin
         tick();
         waited++;
      end
      chk("in_ready_before_beat", 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_first = f;
      in_last  = l;
      tick();
      in_valid = 1'b0;
      chk("east_valid", 64'(out_valid), 64'd1);
      chk("east_a", 64'(out_a), 64'(a));
      chk("south_b", 64'(out_b), 64'(b));
      chk("east_first_last", 64'({out_first, out_last}), 64'({f, l}));
   endtask

   // Send seq_*[0..n-1] with last on the final beat; optionally check latency and result.
   task automatic run_seq(input int n, input bit lat);
      logic [AW-1:0] er;
      bit            eo;
      for (int k = 0; k < n; k++) send_beat(seq_a[k], seq_b[k], seq_f[k], k == n - 1);
      model_seq(n, er, eo);
      if (lat) begin
         chk("in_ready_t1", 64'(in_ready), 64'd0);
         tick();
         chk("in_ready_t2", 64'(in_ready), 64'd0);
         chk("drain_valid_t2", 64'(drain_out_valid), 64'd0);
         tick();
         chk("drain_valid_t3", 64'(drain_out_valid), 64'd1);
         chk("result", 64'(drain_out_data), 64'(er));
         chk("acc_ovf", 64'(acc_ovf), 64'(eo));
         chk("in_ready_t3", 64'(in_ready), 64'd1);
         tick();
         chk("drain_valid_drop", 64'(drain_out_valid), 64'd0);
      end
   endtask

   task automatic chk_reset_state();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_a", 64'(out_a), 64'd0);
      chk("rst_out_b", 64'(out_b), 64'd0);
      chk("rst_out_fl", 64'({out_first, out_last}), 64'd0);
      chk("rst_drain_valid", 64'(drain_out_valid), 64'd0);
      chk("rst_drain_data", 64'(drain_out_data), 64'd0);
      chk("rst_acc_ovf", 64'(acc_ovf), 64'd0);
      chk("rst_protocol_err", 64'(protocol_err), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_drain_in_ready", 64'(drain_in_ready), 64'd1);
   endtask

   initial begin
      reset          = 1'b1;
      in_valid       = 1'b0;
      in_first       = 1'b0;
      in_last        = 1'b0;
      in_a           = '0;
      in_b           = '0;
      drain_in_valid = 1'b0;
      drain_in_data  = '0;
      drain_ready    = 1'b1;

      // Power-on reset.
      tick();
      tick();
      reset = 1'b0;
      chk_reset_state();

      // Single K=1 beat: 1+4+9+16 = 30 at t+3.
      seq_a[0] = pack4(1, 2, 3, 4);
      seq_b[0] = pack4(1, 2, 3, 4);
      seq_f[0] = 1'b1;
      run_seq(1, 1'b1);

      // Three beats of (-1)*5 per lane: -60.
      for (int k = 0; k < 3; k++) begin
         seq_a[k] = pack4(-1, -1, -1, -1);
         seq_b[k] = pack4(5, 5, 5, 5);
         seq_f[k] = (k == 0);
      end
      run_seq(3, 1'b1);

      // Back-pressure: result 30 parks in drain_out, result 8 parks in res_buf.
      drain_ready = 1'b0;
      seq_a[0] = pack4(1, 2, 3, 4);
      seq_b[0] = pack4(1, 2, 3, 4);
      seq_f[0] = 1'b1;
      run_seq(1, 1'b0);
      tick();
      tick();
      tick();
      chk("bp_first_valid", 64'(drain_out_valid), 64'd1);
      chk("bp_first_data", 64'(drain_out_data), 64'd30);
      seq_a[0] = pack4(1, 1, 1, 1);
      seq_b[0] = pack4(2, 2, 2, 2);
      run_seq(1, 1'b0);
      tick();
      tick();
      tick();
      chk("bp_in_ready_blocked", 64'(in_ready), 64'd0);
      drain_in_valid = 1'b1;
      drain_in_data  = 40'h55;
      chk("bp_drain_in_ready_low", 64'(drain_in_ready), 64'd0);
      tick();
      chk("bp_hold_valid", 64'(drain_out_valid), 64'd1);
      chk("bp_hold_data", 64'(drain_out_data), 64'd30);
      drain_ready = 1'b1;
      tick();
      chk("bp_local_valid", 64'(drain_out_valid), 64'd1);
      chk("bp_local_data", 64'(drain_out_data), 64'd8);
      chk("bp_drain_in_ready_high", 64'(drain_in_ready), 64'd1);
      tick();
      drain_in_valid = 1'b0;
      chk("bp_upstream_valid", 64'(drain_out_valid), 64'd1);
      chk("bp_upstream_data", 64'(drain_out_data), 64'h55);
      tick();
      chk("bp_empty", 64'(drain_out_valid), 64'd0);

      // Restart mid-sequence: only the second sequence (24 + 4 = 28) counts.
      chk("perr_clear", 64'(protocol_err), 64'd0);
      seq_a[0] = pack4(1, 1, 1, 1); seq_b[0] = pack4(1, 1, 1, 1); seq_f[0] = 1'b1;
      seq_a[1] = pack4(2, 2, 2, 2); seq_b[1] = pack4(3, 3, 3, 3); seq_f[1] = 1'b1;
      seq_a[2] = pack4(1, 1, 1, 1); seq_b[2] = pack4(1, 1, 1, 1); seq_f[2] = 1'b0;
      run_seq(3, 1'b1);
      chk("perr_restart", 64'(protocol_err), 64'd1);

      // Reset in the middle of a sequence discards it.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      send_beat(pack4(7, 7, 7, 7), pack4(9, 9, 9, 9), 1'b1, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk_reset_state();
      for (int i = 0; i < 5; i++) tick();
      chk("mid_reset_no_result", 64'(drain_out_valid), 64'd0);

      // Beat without first while idle: forwarded, not accumulated, flagged.
      send_beat(pack4(3, 3, 3, 3), pack4(3, 3, 3, 3), 1'b0, 1'b1);
      chk("perr_idle_no_first", 64'(protocol_err), 64'd1);
      for (int i = 0; i < 4; i++) tick();
      chk("idle_beat_no_result", 64'(drain_out_valid), 64'd0);
      chk("idle_out_valid_low", 64'(out_valid), 64'd0);

      // (-32768)^2 * 4 = 2^32 per beat; 130 beats wraps past 2^39.
      for (int k = 0; k < 130; k++) begin
         seq_a[k] = pack4(-32768, -32768, -32768, -32768);
         seq_b[k] = pack4(-32768, -32768, -32768, -32768);
         seq_f[k] = (k == 0);
      end
      run_seq(130, 1'b1);

      // Random sequences of 1..4 beats.
      for (int s = 0; s < 25; s++) begin
         int n;
         n = int'($urandom_range(1, 4));
         for (int k = 0; k < n; k++) begin
            seq_a[k] = {$urandom(), $urandom()};
            seq_b[k] = {$urandom(), $urandom()};
            seq_f[k] = (k == 0);
         end
         run_seq(n, 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
